// File: rtl/dds_pkg.sv
// Shared widths and FSM state encoding for the DDS sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

    localparam int DDS_N     = 32;
    localparam int DDS_CNT_W = 16;
    localparam int DDS_PW_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } dds_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that marks the last cycle of each dwell period.
// Latency: load takes effect on the next edge; expire is combinational from the count.
// Backpressure: none; counts whenever en is high and holds at zero.
import dds_pkg::*;

module dds_dwell_timer #(
    parameter int CNT_W = DDS_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep scheduler driving the DDS fword/pword with per-step dwell.
// Latency: descriptor accepted at edge k gives fword=start and upd in cycle k+1.
// Backpressure: cfg_ready only in IDLE; descriptors offered while busy are not taken.
import dds_pkg::*;

module dds_sweep_ctrl #(
    parameter int N     = DDS_N,
    parameter int CNT_W = DDS_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [N-1:0]        cfg_start,
    input  logic [N-1:0]        cfg_step,
    input  logic [CNT_W-1:0]    cfg_count,
    input  logic [CNT_W-1:0]    cfg_dwell,
    input  logic                cfg_repeat,
    input  logic [DDS_PW_W-1:0] cfg_pword,
    input  logic                abort,
    output logic [N-1:0]        fword,
    output logic [DDS_PW_W-1:0] pword,
    output logic                upd,
    output logic                busy,
    output logic                done
);

    dds_state_t       state, state_nxt;
    logic [N-1:0]     start_q, step_q;
    logic [CNT_W-1:0] count_q, dwell_q, idx;
    logic             repeat_q;
    logic             expire;
    logic             accept, advance, restart, finish, kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Abort is checked before expiry so it wins when both land in one cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        restart   = 1'b0;
        finish    = 1'b0;
        kill      = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    accept    = 1'b1;
                    state_nxt = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    kill      = 1'b1;
                    state_nxt = IDLE;
                end else if (expire) begin
                    if (idx != count_q) begin
                        advance = 1'b1;
                    end else if (repeat_q) begin
                        restart = 1'b1;
                    end else begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    dds_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept | advance | restart),
        .load_val (accept ? cfg_dwell : dwell_q),
        .en       (state == DWELL),
        .expire   (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q  <= '0;
            step_q   <= '0;
            count_q  <= '0;
            dwell_q  <= '0;
            repeat_q <= 1'b0;
            fword    <= '0;
            pword    <= '0;
            idx      <= '0;
            upd      <= 1'b0;
            done     <= 1'b0;
        end else begin
            upd  <= accept | advance | restart | kill;
            done <= finish;
            if (accept) begin
                start_q  <= cfg_start;
                step_q   <= cfg_step;
                count_q  <= cfg_count;
                dwell_q  <= cfg_dwell;
                repeat_q <= cfg_repeat;
                fword    <= cfg_start;
                pword    <= cfg_pword;
                idx      <= '0;
            end else if (kill) begin
                fword <= '0;
            end else if (advance) begin
                fword <= fword + step_q;
                idx   <= idx + CNT_W'(1);
            end else if (restart) begin
                fword <= start_q;
                idx   <= '0;
            end
        end
    end

    assign busy      = (state == DWELL);
    assign cfg_ready = (state == IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed-vector bench for dds_sweep_ctrl; outputs sampled on the falling edge.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_start = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_count = '0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_repeat = 1'b0;
    logic [7:0]  cfg_pword = '0;
    logic        abort = 1'b0;
    logic [31:0] fword;
    logic [7:0]  pword;
    logic        upd, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dds_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_start  (cfg_start),
        .cfg_step   (cfg_step),
        .cfg_count  (cfg_count),
        .cfg_dwell  (cfg_dwell),
        .cfg_repeat (cfg_repeat),
        .cfg_pword  (cfg_pword),
        .abort      (abort),
        .fword      (fword),
        .pword      (pword),
        .upd        (upd),
        .busy       (busy),
        .done       (done)
    );

    // Called at a falling edge; returns at the falling edge of the first sweep cycle.
    task automatic send(input logic [31:0] s, input logic [31:0] st, input logic [15:0] c,
                        input logic [15:0] d, input logic r, input logic [7:0] p);
        cfg_start = s; cfg_step = st; cfg_count = c; cfg_dwell = d;
        cfg_repeat = r; cfg_pword = p; cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({fword, pword, upd, busy, done} !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got fw=%h pw=%h upd=%b busy=%b done=%b want all zero",
                     fword, pword, upd, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready got ready=%b busy=%b want ready=1 busy=0", cfg_ready, busy);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] ef;
        logic eu, eb, ed;
        int pulses = 0;
        send(32'd429497, 32'd100000, 16'd3, 16'd4, 1'b0, 8'h5A);
        for (int c = 0; c <= 20; c++) begin
            ef = 32'd429497 + 32'd100000 * 32'((c < 20 ? c : 19) / 5);
            eu = (c < 20) && (c % 5 == 0);
            eb = (c < 20);
            ed = (c == 20);
            pulses += int'(upd);
            n_cmp++;
            if ({fword, pword, upd, busy, done, cfg_ready} !== {ef, 8'h5A, eu, eb, ed, ~eb}) begin
                n_bad++;
                $display("FAIL oneshot c=%0d got fw=%0d pw=%h upd=%b busy=%b done=%b rdy=%b want fw=%0d upd=%b busy=%b done=%b",
                         c, fword, pword, upd, busy, done, cfg_ready, ef, eu, eb, ed);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pulses != 4 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_pulses got upd_count=%0d done_after=%b want 4 and 0", pulses, done);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_fw [3];
        logic [2:0]  exp_ctl [3];
        exp_fw[0] = 32'hFFFFFF00; exp_fw[1] = 32'h00000100; exp_fw[2] = 32'h00000100;
        exp_ctl[0] = 3'b110; exp_ctl[1] = 3'b110; exp_ctl[2] = 3'b001;
        send(32'hFFFFFF00, 32'h200, 16'd1, 16'd0, 1'b0, 8'h00);
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({fword, upd, busy, done} !== {exp_fw[c], exp_ctl[c]}) begin
                n_bad++;
                $display("FAIL wrap c=%0d got fw=%h upd/busy/done=%b%b%b want fw=%h %b",
                         c, fword, upd, busy, done, exp_fw[c], exp_ctl[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_repeat_abort();
        logic [31:0] ef;
        send(32'd10, 32'd5, 16'd1, 16'd1, 1'b1, 8'h00);
        for (int c = 0; c < 10; c++) begin
            ef = ((c / 2) % 2 == 0) ? 32'd10 : 32'd15;
            n_cmp++;
            if ({fword, upd, busy, done} !== {ef, (c % 2 == 0), 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL repeat c=%0d got fw=%0d upd=%b busy=%b done=%b want fw=%0d upd=%b busy=1 done=0",
                         c, fword, upd, busy, done, ef, (c % 2 == 0));
            end
            @(negedge clk);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({fword, upd, busy, done, cfg_ready} !== {32'd0, 4'b1001}) begin
            n_bad++;
            $display("FAIL repeat_abort got fw=%0d upd=%b busy=%b done=%b rdy=%b want fw=0 upd=1 busy=0 done=0 rdy=1",
                     fword, upd, busy, done, cfg_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({fword, upd} !== {32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL abort_settle got fw=%0d upd=%b want fw=0 upd=0", fword, upd);
        end
    endtask

    task automatic test_abort_on_expiry();
        send(32'd100, 32'd1, 16'd1, 16'd0, 1'b0, 8'h00);
        @(negedge clk);
        n_cmp++;
        if ({fword, busy} !== {32'd101, 1'b1}) begin
            n_bad++;
            $display("FAIL abort_exp_pre got fw=%0d busy=%b want fw=101 busy=1", fword, busy);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({fword, upd, busy, done} !== {32'd0, 3'b100}) begin
            n_bad++;
            $display("FAIL abort_exp got fw=%0d upd=%b busy=%b done=%b want fw=0 upd=1 busy=0 done=0",
                     fword, upd, busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_exp_nodone got done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_fw [9];
        logic [3:0]  exp_ctl [9];
        exp_fw[0] = 32'd1000; exp_fw[1] = 32'd1000; exp_fw[2] = 32'd1010; exp_fw[3] = 32'd1010;
        exp_fw[4] = 32'd1010; exp_fw[5] = 32'd50;   exp_fw[6] = 32'd50;   exp_fw[7] = 32'd50;
        exp_fw[8] = 32'd50;
        // upd, busy, done, cfg_ready
        exp_ctl[0] = 4'b1100; exp_ctl[1] = 4'b0100; exp_ctl[2] = 4'b1100; exp_ctl[3] = 4'b0100;
        exp_ctl[4] = 4'b0011; exp_ctl[5] = 4'b1100; exp_ctl[6] = 4'b0100; exp_ctl[7] = 4'b0100;
        exp_ctl[8] = 4'b0011;
        cfg_start = 32'd1000; cfg_step = 32'd10; cfg_count = 16'd1; cfg_dwell = 16'd1;
        cfg_repeat = 1'b0; cfg_pword = 8'h11; cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_start = 32'd50; cfg_step = 32'd3; cfg_count = 16'd0; cfg_dwell = 16'd2;
        cfg_pword = 8'h22;
        for (int c = 0; c < 9; c++) begin
            if (c == 5) cfg_valid = 1'b0;
            n_cmp++;
            if ({fword, upd, busy, done, cfg_ready} !== {exp_fw[c], exp_ctl[c]}) begin
                n_bad++;
                $display("FAIL b2b c=%0d got fw=%0d upd/busy/done/rdy=%b%b%b%b want fw=%0d %b",
                         c, fword, upd, busy, done, cfg_ready, exp_fw[c], exp_ctl[c]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (pword !== 8'h22) begin
            n_bad++;
            $display("FAIL b2b_pword got %h want 22", pword);
        end
    endtask

    task automatic test_reset_mid();
        send(32'd7, 32'd1, 16'd5, 16'd10, 1'b0, 8'h33);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({fword, pword, upd, busy, done} !== 43'd0) begin
            n_bad++;
            $display("FAIL reset_mid got fw=%h pw=%h upd=%b busy=%b done=%b want all zero",
                     fword, pword, upd, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cfg_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_mid_ready got rdy=%b busy=%b want rdy=1 busy=0", cfg_ready, busy);
        end
        send(32'd20, 32'd2, 16'd0, 16'd0, 1'b0, 8'h01);
        n_cmp++;
        if ({fword, pword, upd, busy, done} !== {32'd20, 8'h01, 3'b110}) begin
            n_bad++;
            $display("FAIL restart_first got fw=%0d pw=%h upd=%b busy=%b done=%b want fw=20 pw=01 upd=1 busy=1 done=0",
                     fword, pword, upd, busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if ({fword, upd, busy, done} !== {32'd20, 3'b001}) begin
            n_bad++;
            $display("FAIL restart_done got fw=%0d upd=%b busy=%b done=%b want fw=20 upd=0 busy=0 done=1",
                     fword, upd, busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_wrap();
        test_repeat_abort();
        test_abort_on_expiry();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
